ir_transmit: RTL and testbench
==============================

IR_TRANSMIT -- requirements
Module: ir_transmit

Interface
REQ-001 SHALL have parameter T_UNIT, default 28125, meaning the NEC base unit in iCLK cycles (562.5 us at 50 MHz).
REQ-002 SHALL have parameter CARRIER_HALF, default 658, meaning the carrier half-period in iCLK cycles (~38 kHz).
REQ-003 SHALL have parameter CARRIER_EN, default 1, meaning that 1 modulates marks and 0 drives oIRDA equal to oENV.
REQ-004 SHALL have parameter FRAME_UNITS, default 192, meaning the frame repetition period in T_UNITs (108 ms).
REQ-005 SHALL have port iCLK, input, 1 bit: the single clock (CLOCK_50); all logic is clocked on its rising edge.
REQ-006 SHALL have port iRST, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port iSTART, input, 1 bit: request a full frame; it is accepted only in a cycle where oBUSY=0.
REQ-008 SHALL have port iDATA, input, 32 bits: frame payload, latched on acceptance and sent LSB first, bit 0 to bit 31 (the receiver's oDATA layout: [15:0] custom, [23:16] key, [31:24] ~key).
REQ-009 SHALL have port iREPEAT, input, 1 bit: key held; sampled only at period end.
REQ-010 SHALL have port oBUSY, output, 1 bit: high from acceptance until period end.
REQ-011 SHALL have port oDONE, output, 1 bit: one-cycle pulse at period end.
REQ-012 SHALL have port oENV, output, 1 bit: unmodulated envelope, 1 = mark.
REQ-013 SHALL have port oIRDA, output, 1 bit: LED drive, carrier-modulated during marks, 0 during spaces.

Function
REQ-014 SHALL implement the states IDLE, LEAD_MARK (16 units), LEAD_SPACE (8 units), BIT_MARK (1 unit), BIT_SPACE (1 unit for bit=0, 3 units for bit=1), STOP_MARK (1 unit), REP_MARK (16 units), REP_SPACE (4 units), REP_STOP (1 unit), and GAP (low until period end).
REQ-015 SHALL, for a full frame, run LEAD_MARK → LEAD_SPACE → 32×(BIT_MARK → BIT_SPACE) → STOP_MARK → GAP, with a 5-bit bit counter running 0..31.
REQ-016 SHALL, for a repeat frame, run REP_MARK → REP_SPACE → REP_STOP → GAP.
REQ-017 SHALL, when iSTART is accepted in cycle 0, capture iDATA, assert oBUSY and raise oENV in cycle 1; every state duration SHALL be exact (units × T_UNIT cycles).
REQ-018 SHALL run a period counter from the first mark cycle; at FRAME_UNITS×T_UNIT cycles (the end cycle E), oDONE=1 and oBUSY=0 for cycle E.
REQ-019 SHALL, in cycle E: if iSTART=1, accept a new frame; else if iREPEAT=1 and a full frame has completed since reset, start a repeat frame; either SHALL raise oENV at E+1 (back-to-back periods, no extra idle cycle); otherwise go to IDLE.
REQ-020 SHALL ignore iSTART while oBUSY=1 and SHALL NOT corrupt the latched data.
REQ-021 SHALL ignore iREPEAT except in cycle E, and SHALL ignore iREPEAT when no full frame has completed since reset.
REQ-022 SHALL, with CARRIER_EN=1, restart the carrier counter at every mark start, so that oIRDA is 1 in the first mark cycle and toggles every CARRIER_HALF cycles; oIRDA SHALL be 0 whenever oENV=0.
REQ-023 SHALL drive all outputs from registers, with no combinational path from input to output.
REQ-024 SHALL keep the frame length at or below 153 units, which always fits within FRAME_UNITS; GAP length = period minus frame length.

Reset
REQ-025 SHALL, on iRST=1 at a clock edge, force IDLE with oBUSY=0, oDONE=0, oENV=0, oIRDA=0, the "frame sent" flag cleared, and all counters at 0.
REQ-026 SHALL let iRST take effect from any state, including mid-mark, and SHALL give iRST priority over iSTART in the same cycle.
REQ-027 SHALL produce no oDONE for a frame aborted by reset.

Verification (T_UNIT=4, CARRIER_HALF=1, FRAME_UNITS=192, so one period = 768 cycles)
REQ-028 SHALL be verified by: iRST held 2 cycles, then released → all outputs 0, and iREPEAT=1 alone does not start a transmission.
REQ-029 SHALL be verified by: iSTART with iDATA=32'hE51A00FF at cycle 0 → oENV high cycles 1-64, low 65-96; bits 0-7 each give 4 high + 12 low; bits 8-15 each give 4 high + 4 low; a decoding monitor recovers 32'hE51A00FF; stop mark of 4 cycles; oDONE at cycle 768.
REQ-030 SHALL be verified by: iSTART pulsed again at cycle 100 with iDATA=32'h0 → ignored; the transmitted bits remain E51A00FF.
REQ-031 SHALL be verified by: iREPEAT held high through cycle 768 → oENV 64 high, 16 low, 4 high starting at cycle 769; oDONE at cycle 1536; repeats continue until iREPEAT falls.
REQ-032 SHALL be verified by: iRST asserted at cycle 150 (mid-bit) → oENV=oIRDA=oBUSY=0 next cycle; no oDONE follows; a subsequent iSTART produces a complete, correct frame.
REQ-033 SHALL be verified by: inspecting the carrier during any mark → oIRDA pattern 1,0,1,0 starting high; with CARRIER_EN=0, oIRDA equals oENV on every cycle.

Source files
------------

// File: rtl/ir_transmit.sv
// ir_transmit: NEC infrared frame transmitter with repeat frames and ~38 kHz carrier.
// Outputs are registered copies of the next-state decode, so nothing from an input reaches an output combinationally.
module ir_transmit #(
    parameter int T_UNIT       = 28125,
    parameter int CARRIER_HALF = 658,
    parameter int CARRIER_EN   = 1,
    parameter int FRAME_UNITS  = 192
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iSTART,
    input  logic [31:0] iDATA,
    input  logic        iREPEAT,
    output logic        oBUSY,
    output logic        oDONE,
    output logic        oENV,
    output logic        oIRDA
);
    localparam int PERIOD = FRAME_UNITS * T_UNIT;
    localparam int PW     = $clog2(PERIOD + 1);
    localparam int CW     = $clog2(16 * T_UNIT);
    localparam int KW     = $clog2(CARRIER_HALF + 1);

    typedef enum logic [3:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK,
        REP_MARK, REP_SPACE, REP_STOP, GAP
    } state_t;

    state_t          r_state, w_state_n;
    logic [CW-1:0]   r_cnt, w_cnt_n;
    logic [PW-1:0]   r_per, w_per_n;
    logic [4:0]      r_bit, w_bit_n;
    logic [31:0]     r_data, w_data_n;
    logic            r_sent, w_sent_n;
    logic [KW-1:0]   r_ccnt, w_ccnt_n;
    logic            r_car, w_car_n;
    logic            r_busy, r_done, r_env, r_irda;
    logic [4:0]      w_units;
    logic            w_seg_end, w_end, w_accept, w_mark_n, w_done_n, w_busy_n;
    logic            w_cstart, w_ctog, w_irda_n;

    always_comb begin
        w_units   = (r_state == LEAD_MARK || r_state == REP_MARK) ? 5'd16 :
                    (r_state == LEAD_SPACE) ? 5'd8 :
                    (r_state == REP_SPACE) ? 5'd4 :
                    (r_state == BIT_SPACE && r_data[r_bit]) ? 5'd3 : 5'd1;
        w_seg_end = r_cnt == CW'(w_units * T_UNIT - 1);
        w_end     = r_state == GAP && r_per == PW'(PERIOD);
        w_accept  = iSTART && (r_state == IDLE || w_end);
        w_state_n = r_state;
        w_cnt_n   = w_seg_end ? '0 : r_cnt + 1'b1;
        w_per_n   = r_per + 1'b1;
        w_bit_n   = r_bit;
        w_data_n  = r_data;
        w_sent_n  = r_sent;
        if (w_accept) begin
            w_state_n = LEAD_MARK;
            w_per_n   = PW'(1);
            w_cnt_n   = '0;
            w_bit_n   = '0;
            w_data_n  = iDATA;
        end else if (w_end && iREPEAT && r_sent) begin
            w_state_n = REP_MARK;
            w_per_n   = PW'(1);
            w_cnt_n   = '0;
        end else if (r_state == IDLE || w_end) begin
            w_state_n = IDLE;
            w_per_n   = '0;
            w_cnt_n   = '0;
        end else if (w_seg_end) begin
            case (r_state)
                LEAD_MARK:  w_state_n = LEAD_SPACE;
                LEAD_SPACE: w_state_n = BIT_MARK;
                BIT_MARK:   w_state_n = BIT_SPACE;
                BIT_SPACE: begin
                    w_bit_n   = r_bit + 1'b1;
                    w_state_n = &r_bit ? STOP_MARK : BIT_MARK;
                end
                STOP_MARK: begin
                    w_state_n = GAP;
                    w_sent_n  = 1'b1;
                end
                REP_MARK:   w_state_n = REP_SPACE;
                REP_SPACE:  w_state_n = REP_STOP;
                REP_STOP:   w_state_n = GAP;
                default:    w_state_n = r_state;
            endcase
        end
        w_mark_n = w_state_n inside {LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP};
        w_done_n = w_state_n == GAP && w_per_n == PW'(PERIOD);
        w_busy_n = w_state_n != IDLE && !w_done_n;
        // carrier phase restarts high on every space-to-mark transition
        w_cstart = w_mark_n && !r_env;
        w_ctog   = r_ccnt == KW'(CARRIER_HALF - 1);
        w_ccnt_n = (w_cstart || w_ctog) ? '0 : r_ccnt + 1'b1;
        w_car_n  = w_cstart ? 1'b1 : w_ctog ? ~r_car : r_car;
        w_irda_n = w_mark_n && (CARRIER_EN == 0 || w_car_n);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_per   <= '0;
            r_bit   <= '0;
            r_data  <= '0;
            r_sent  <= 1'b0;
            r_ccnt  <= '0;
            r_car   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_env   <= 1'b0;
            r_irda  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_per   <= w_per_n;
            r_bit   <= w_bit_n;
            r_data  <= w_data_n;
            r_sent  <= w_sent_n;
            r_ccnt  <= w_ccnt_n;
            r_car   <= w_car_n;
            r_busy  <= w_busy_n;
            r_done  <= w_done_n;
            r_env   <= w_mark_n;
            r_irda  <= w_irda_n;
        end
    end

    assign oBUSY = r_busy;
    assign oDONE = r_done;
    assign oENV  = r_env;
    assign oIRDA = r_irda;
endmodule

// File: tb/tb_ir_transmit.sv
// tb_ir_transmit: expected frames/repeats/done pulses are queued by the stimulus;
// an envelope-decoding monitor pops and compares them as the DUT produces them.
module tb_ir_transmit;
    logic        iCLK = 1'b0;
    logic        iRST, iSTART, iREPEAT;
    logic [31:0] iDATA;
    logic        oBUSY, oDONE, oENV, oIRDA;
    logic        busy0, done0, env0, irda0;

    typedef struct packed {
        int          kind;
        int          cyc;
        logic [31:0] data;
    } ev_t;

    ev_t         q[$];
    int          n_cmp = 0, n_bad = 0, cyc = 0, bad0 = 0;
    int          ds = 0, nb = 0, run = 0, cbad = 0, fstart = 0;
    logic [31:0] dd = '0;
    logic        prev = 1'b0;

    ir_transmit #(.T_UNIT(4), .CARRIER_HALF(1), .CARRIER_EN(1), .FRAME_UNITS(192)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iDATA(iDATA), .iREPEAT(iREPEAT),
        .oBUSY(oBUSY), .oDONE(oDONE), .oENV(oENV), .oIRDA(oIRDA));

    ir_transmit #(.T_UNIT(4), .CARRIER_HALF(1), .CARRIER_EN(0), .FRAME_UNITS(192)) dut0 (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iDATA(iDATA), .iREPEAT(iREPEAT),
        .oBUSY(busy0), .oDONE(done0), .oENV(env0), .oIRDA(irda0));

    always #5 iCLK = ~iCLK;
    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(string nm, logic act, logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic expect_ev(int k, logic [31:0] d, int c);
        q.push_back('{kind: k, cyc: c, data: d});
    endtask

    // kind 0 = full frame, 1 = repeat frame, 2 = done pulse
    task automatic got(int kind, logic [31:0] data, int c);
        ev_t e;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, c);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", c, e.cyc);
            if (kind == 0) chk("frame_data", data, e.data);
        end
    endtask

    always @(negedge iCLK) begin
        if (iRST) begin
            ds = 0; prev = 1'b0; run = 0; cbad = 0;
        end else begin
            if (oENV !== prev) begin
                chk("carrier", cbad, 0);
                cbad = 0;
                if (prev) begin
                    case (ds)
                        0: begin chk("lead_mark_len", run, 64); ds = 1; end
                        2: begin
                            chk("bit_mark_len", run, 4);
                            if (nb == 32) begin got(0, dd, fstart); ds = 0; end
                            else ds = 3;
                        end
                        4: begin chk("rep_stop_len", run, 4); got(1, 0, fstart); ds = 0; end
                        default: begin chk("mark_in_state", ds, 2); ds = 0; end
                    endcase
                end else begin
                    case (ds)
                        1: if (run == 32) begin ds = 2; nb = 0; dd = '0; end
                           else if (run == 16) ds = 4;
                           else begin chk("lead_space_len", run, 32); ds = 0; end
                        3: begin
                            if (run != 4) chk("bit_space_len", run, 12);
                            dd[nb] = (run == 12);
                            nb++;
                            ds = 2;
                        end
                        default: ;
                    endcase
                    if (ds == 0) fstart = cyc;
                end
                run = 1;
            end else run++;
            if (oIRDA !== (oENV && (run % 2 == 1))) cbad++;
            if (oDONE) begin
                got(2, 0, cyc);
                chk1("busy_at_done", oBUSY, 1'b0);
            end
            prev = oENV;
        end
    end

    always @(negedge iCLK)
        if (!iRST && (irda0 !== env0 || env0 !== oENV || busy0 !== oBUSY || done0 !== oDONE)) bad0++;

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic at(int c);
        while (cyc < c) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2;
        iRST = 1'b1; iSTART = 1'b0; iREPEAT = 1'b0; iDATA = '0;
        step(); step();
        iRST = 1'b0;
        chk1("rst_busy", oBUSY, 1'b0);
        chk1("rst_done", oDONE, 1'b0);
        chk1("rst_env", oENV, 1'b0);
        chk1("rst_irda", oIRDA, 1'b0);
        iREPEAT = 1'b1;
        repeat (20) step();
        chk1("repeat_alone_busy", oBUSY, 1'b0);
        chk1("repeat_alone_env", oENV, 1'b0);
        iREPEAT = 1'b0;

        t0 = cyc;
        iSTART = 1'b1; iDATA = 32'hE51A00FF;
        expect_ev(0, 32'hE51A00FF, t0 + 1);
        expect_ev(2, 0, t0 + 768);
        expect_ev(1, 0, t0 + 769);
        expect_ev(2, 0, t0 + 1536);
        expect_ev(1, 0, t0 + 1537);
        expect_ev(2, 0, t0 + 2304);
        step();
        iSTART = 1'b0;
        chk1("start_busy", oBUSY, 1'b1);
        chk1("start_env", oENV, 1'b1);
        at(t0 + 100);
        iSTART = 1'b1; iDATA = 32'h0;
        step();
        iSTART = 1'b0;
        at(t0 + 700);
        iREPEAT = 1'b1;
        at(t0 + 768);
        chk1("end_done", oDONE, 1'b1);
        chk1("end_busy", oBUSY, 1'b0);
        at(t0 + 1600);
        iREPEAT = 1'b0;
        at(t0 + 2310);
        chk1("idle_after_repeat", oBUSY, 1'b0);

        t1 = cyc;
        iSTART = 1'b1; iDATA = 32'h1234ABCD;
        step();
        iSTART = 1'b0;
        at(t1 + 150);
        iRST = 1'b1; iSTART = 1'b1;
        step();
        chk1("abort_env", oENV, 1'b0);
        chk1("abort_irda", oIRDA, 1'b0);
        chk1("abort_busy", oBUSY, 1'b0);
        step();
        iRST = 1'b0; iSTART = 1'b0;
        chk1("rst_over_start_busy", oBUSY, 1'b0);
        at(t1 + 900);

        t2 = cyc;
        iSTART = 1'b1; iDATA = 32'h1234ABCD;
        expect_ev(0, 32'h1234ABCD, t2 + 1);
        expect_ev(2, 0, t2 + 768);
        expect_ev(0, 32'hA5C30F12, t2 + 769);
        expect_ev(2, 0, t2 + 1536);
        step();
        iSTART = 1'b0;
        at(t2 + 768);
        iSTART = 1'b1; iDATA = 32'hA5C30F12; iREPEAT = 1'b1;
        step();
        iSTART = 1'b0; iREPEAT = 1'b0;
        at(t2 + 1540);
        for (int i = 0; i < 2000 && q.size() > 0; i++) step();
        chk("queue_drained", q.size(), 0);
        chk("carrier_off_match", bad0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
